// File: rtl/n_bit_subtractor_full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit subtractor cell, used as a single stage of the ripple-borrow chain
// in n_bit_subtractor.
//
// Ports:
//   a   in   1  minuend bit
//   b   in   1  subtrahend bit
//   bin in   1  borrow into this stage (weight 1)
//   d   out  1  difference bit, a - b - bin
//   bo  out  1  borrow out of this stage
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bin;

    // A stage borrows when b beats a outright, or when a and b tie and the
    // incoming borrow still has to be paid.
    assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/n_bit_subtractor.sv
// -----------------------------------------------------------------------------
// n_bit_subtractor
// Unsigned N-bit subtractor that produces an N+1-bit two's-complement
// difference, (in1 - in2 - cin) mod 2^(N+1). It is built from a ripple-borrow
// chain of full_subtractor cells. The combinational result is also registered
// once, with a synchronous clear.
//
// Parameters:
//   IN_DATAWIDTH  operand width N, 1..64
//
// Ports:
//   clk    in   1    rising-edge clock for sum_q
//   rst    in   1    synchronous active-high clear of sum_q
//   in1    in   N    minuend, unsigned
//   in2    in   N    subtrahend, unsigned
//   cin    in   1    borrow-in, subtracted with weight 1
//   sum    out  N+1  combinational difference; sum[N] is the final borrow
//   sum_q  out  N+1  sum delayed by one clock
//   bout   out  1    combinational borrow-out, identical to sum[N]
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module n_bit_subtractor #(
    parameter int IN_DATAWIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IN_DATAWIDTH-1:0] in1,
    input  logic [IN_DATAWIDTH-1:0] in2,
    input  logic                    cin,
    output logic [IN_DATAWIDTH:0]   sum,
    output logic [IN_DATAWIDTH:0]   sum_q,
    output logic                    bout
);

    // The result is one bit wider than the operands so that the whole
    // difference range [-2^N, 2^N-1] fits. Because this is a localparam, the
    // width cannot be set independently of IN_DATAWIDTH.
    localparam int OUT_DATAWIDTH = IN_DATAWIDTH + 1;

    // borrow[i] is the borrow entering stage i. borrow[N] leaves the top stage.
    logic [OUT_DATAWIDTH-1:0] borrow;
    logic [IN_DATAWIDTH-1:0]  diff;

    assign borrow[0] = cin;

    // Ripple-borrow chain, LSB first: each stage takes its borrow from the
    // stage below it.
    genvar i;
    generate
        for (i = 0; i < IN_DATAWIDTH; i++) begin : g_stage
            full_subtractor u_cell (
                .a   (in1[i]),
                .b   (in2[i]),
                .bin (borrow[i]),
                .d   (diff[i]),
                .bo  (borrow[i+1])
            );
        end
    endgenerate

    // The final borrow serves as the sign bit of the wider result.
    assign sum  = {borrow[IN_DATAWIDTH], diff};
    assign bout = borrow[IN_DATAWIDTH];

    // The registered copy of the difference. Reset clears only this register.
    // sum and bout keep tracking the inputs while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum;
        end
    end

endmodule

// File: tb/tb_n_bit_subtractor.sv
`timescale 1ns/1ps

module tb_n_bit_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [7:0]  in1_8, in2_8;
    logic        cin_8;
    logic [8:0]  sum_8, sum_q_8;
    logic        bout_8;

    logic [0:0]  in1_1, in2_1;
    logic        cin_1;
    logic [1:0]  sum_1, sum_q_1;
    logic        bout_1;

    logic [15:0] in1_16, in2_16;
    logic        cin_16;
    logic [16:0] sum_16, sum_q_16;
    logic        bout_16;

    int assert_count = 0;
    int fail_count   = 0;

    always #5 clk = ~clk;

    n_bit_subtractor #(.IN_DATAWIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in1(in1_8), .in2(in2_8), .cin(cin_8),
        .sum(sum_8), .sum_q(sum_q_8), .bout(bout_8)
    );

    n_bit_subtractor #(.IN_DATAWIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in1(in1_1), .in2(in2_1), .cin(cin_1),
        .sum(sum_1), .sum_q(sum_q_1), .bout(bout_1)
    );

    n_bit_subtractor #(.IN_DATAWIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in1(in1_16), .in2(in2_16), .cin(cin_16),
        .sum(sum_16), .sum_q(sum_q_16), .bout(bout_16)
    );

    // Reference model: the plain arithmetic difference, reduced mod 2^(n+1).
    function automatic longint unsigned ref_diff(input longint unsigned a,
                                                 input longint unsigned b,
                                                 input longint unsigned c,
                                                 input int n);
        longint unsigned m;
        m = (64'd1 << (n + 1)) - 64'd1;
        return (a - b - c) & m;
    endfunction

    // The borrow-out is set exactly when the minuend is smaller than the
    // subtrahend plus the borrow-in.
    function automatic logic ref_borrow(input longint unsigned a,
                                        input longint unsigned b,
                                        input longint unsigned c);
        return (a < b + c);
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus_8(input logic [7:0] a, input logic [7:0] b, input logic c);
        in1_8 = a;
        in2_8 = b;
        cin_8 = c;
        #1;
    endtask

    task automatic check_8(input string tag);
        check_output({tag, " sum"},  sum_8,  ref_diff(in1_8, in2_8, cin_8, 8));
        check_output({tag, " bout"}, bout_8, ref_borrow(in1_8, in2_8, cin_8));
    endtask

    // Watchdog: end the run with a failure line if it ever stops advancing.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        longint unsigned exp_q8, exp_q16;
        logic            r;

        in1_8 = '0;  in2_8 = '0;  cin_8 = 1'b0;
        in1_1 = '0;  in2_1 = '0;  cin_1 = 1'b0;
        in1_16 = '0; in2_16 = '0; cin_16 = 1'b0;

        // The register is cleared after two edges with reset held.
        repeat (2) @(posedge clk);
        #1;
        check_output("reset sum_q n8",  sum_q_8,  0);
        check_output("reset sum_q n1",  sum_q_1,  0);
        check_output("reset sum_q n16", sum_q_16, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed and extreme vectors with N=8.
        apply_stimulus_8(8'd5, 8'd3, 1'b1);
        check_output("dir 5-3-1 sum",  sum_8, 9'h001);
        check_output("dir 5-3-1 bout", bout_8, 1'b0);
        apply_stimulus_8(8'd0, 8'd1, 1'b0);
        check_output("dir 0-1 sum",  sum_8, 9'h1FF);
        check_output("dir 0-1 bout", bout_8, 1'b1);
        apply_stimulus_8(8'd255, 8'd0, 1'b0);
        check_output("ext 255-0 sum", sum_8, 9'h0FF);
        apply_stimulus_8(8'd0, 8'd255, 1'b1);
        check_output("ext 0-255-1 sum",  sum_8, 9'h100);
        check_output("ext 0-255-1 bout", bout_8, 1'b1);
        apply_stimulus_8(8'd77, 8'd77, 1'b0);
        check_output("eq cin0 sum", sum_8, 9'h000);
        apply_stimulus_8(8'd77, 8'd77, 1'b1);
        check_output("eq cin1 sum", sum_8, 9'h1FF);

        // Exhaustive check with N=8 while the clock keeps running.
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                for (int c = 0; c < 2; c++) begin
                    apply_stimulus_8(8'(a), 8'(b), 1'(c));
                    check_8($sformatf("exh %0d-%0d-%0d", a, b, c));
                end
            end
        end

        // Exhaustive check with N=1.
        for (int k = 0; k < 8; k++) begin
            in1_1 = 1'(k >> 2);
            in2_1 = 1'(k >> 1);
            cin_1 = 1'(k);
            #1;
            check_output($sformatf("n1 case %0d sum", k), sum_1,
                         ref_diff(in1_1, in2_1, cin_1, 1));
            check_output($sformatf("n1 case %0d bout", k), bout_1,
                         ref_borrow(in1_1, in2_1, cin_1));
        end

        // N=16: the corner vectors, then 10000 random vectors.
        for (int k = 0; k < 8; k++) begin
            in1_16 = (k & 4) ? 16'hFFFF : 16'h0000;
            in2_16 = (k & 2) ? 16'hFFFF : 16'h0000;
            cin_16 = 1'(k);
            #1;
            check_output($sformatf("n16 corner %0d", k), sum_16,
                         ref_diff(in1_16, in2_16, cin_16, 16));
        end
        for (int k = 0; k < 10000; k++) begin
            in1_16 = 16'($urandom);
            in2_16 = 16'($urandom);
            cin_16 = 1'($urandom);
            #1;
            check_output($sformatf("n16 rnd %0d sum", k), sum_16,
                         ref_diff(in1_16, in2_16, cin_16, 16));
            check_output($sformatf("n16 rnd %0d bout", k), bout_16,
                         ref_borrow(in1_16, in2_16, cin_16));
        end

        // Register path: hold reset across two edges, release it, then change
        // the operands.
        @(negedge clk);
        rst = 1'b1;
        in1_8 = 8'd200; in2_8 = 8'd50; cin_8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("regpath rst sum_q", sum_q_8, 9'd0);
        check_output("regpath rst sum",   sum_8,   9'd150);
        @(negedge clk);
        rst = 1'b0;
        check_output("regpath hold sum_q", sum_q_8, 9'd0);
        @(posedge clk);
        #1;
        check_output("regpath load sum_q", sum_q_8, 9'd150);
        @(negedge clk);
        in1_8 = 8'd10; in2_8 = 8'd20;
        @(posedge clk);
        #1;
        check_output("regpath neg sum_q", sum_q_8, 9'h1F6);

        // Random cycles with reset toggled at random. Expected register
        // contents are the reference difference of the operands at that edge,
        // or zero when reset is high.
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            r = ($urandom_range(0, 7) == 0);
            rst = r;
            in1_8  = 8'($urandom);  in2_8  = 8'($urandom);  cin_8  = 1'($urandom);
            in1_16 = 16'($urandom); in2_16 = 16'($urandom); cin_16 = 1'($urandom);
            exp_q8  = r ? 0 : ref_diff(in1_8, in2_8, cin_8, 8);
            exp_q16 = r ? 0 : ref_diff(in1_16, in2_16, cin_16, 16);
            #1;
            check_output($sformatf("rnd cyc %0d sum n8", k), sum_8,
                         ref_diff(in1_8, in2_8, cin_8, 8));
            @(posedge clk);
            #1;
            check_output($sformatf("rnd cyc %0d sum_q n8", k),  sum_q_8,  exp_q8);
            check_output($sformatf("rnd cyc %0d sum_q n16", k), sum_q_16, exp_q16);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/n_bit_subtractor.md
N_BIT_SUBTRACTOR -- requirements
Module: n_bit_subtractor

Interface
REQ-001 Parameter IN_DATAWIDTH, default 8: operand width N; legal range 1..64.
REQ-002 Parameter OUT_DATAWIDTH, default IN_DATAWIDTH+1: result width, always N+1; not overridable independently.
REQ-003 clk  input  1  single clock; all registered state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in1  input  N  minuend, unsigned.
REQ-006 in2  input  N  subtrahend, unsigned.
REQ-007 cin  input  1  borrow-in, subtracted with weight 1.
REQ-008 sum  output  N+1  combinational difference.
REQ-009 sum_q  output  N+1  registered copy of sum.
REQ-010 bout  output  1  combinational borrow-out, equal to sum[N].

Function
REQ-011 sum SHALL equal (in1 - in2 - cin) mod 2^(N+1), i.e. the N+1-bit two's-complement difference.
REQ-012 sum SHALL be purely combinational, with zero-cycle latency from any input change; it has no clk or rst dependency.
REQ-013 sum[N-1:0] SHALL be the N-bit modular difference, and sum[N] SHALL be 1 exactly when in1 < in2 + cin.
REQ-014 Boundary cases: in1=in2 with cin=0 gives 0; in1=in2 with cin=1 gives all ones (2^(N+1)-1); in1=0, in2=2^N-1, cin=1 gives 2^N.
REQ-015 No overflow or saturation: every input combination maps to exactly one N+1-bit result, and the difference range [-2^N, 2^N-1] fits in N+1 bits.
REQ-016 sum_q SHALL load sum on every rising clk edge when rst=0, giving 1-cycle latency.
REQ-017 No enable and no handshake: the block accepts new operands every cycle.
REQ-018 X or Z on any input bit MAY propagate to sum; no masking is required.

Reset
REQ-019 When rst=1 at a rising clk edge, sum_q SHALL become 0 on that edge, overriding the load.
REQ-020 Reset SHALL NOT affect sum or bout, which track the inputs at all times, including during reset.
REQ-021 Deasserting rst mid-stream: sum_q SHALL hold 0 until the first rising edge with rst=0, then load the current sum.

Structure
REQ-022 No shared package: the block has no typedefs, and OUT_DATAWIDTH is derived locally.
REQ-023 One sub-module, full_subtractor, SHALL implement the 1-bit cell: inputs a, b, bin; outputs d = a^b^bin and bo = (~a&b) | (~(a^b)&bin).
REQ-024 A generate loop SHALL chain N full_subtractor instances as a ripple-borrow chain, LSB first:
- stage 0 takes bin = cin;
- stage i takes bin from the bo of stage i-1.
REQ-025 Chain outputs map as follows: each stage's d drives sum[i], and the final bo drives both sum[N] and bout.
REQ-026 Only sum_q is sequential; there are no other flops and no latches.

Verification
REQ-027 Exhaustive (N=8), with clk toggling: all in1 0..255 × in2 0..255 × cin 0/1; after 1 time unit, sum == (in1-in2-cin) mod 512 for all 131072 combinations, with zero mismatches.
REQ-028 Directed (N=8):
- in1=5, in2=3, cin=1 -> sum=9'h001, bout=0;
- in1=0, in2=1, cin=0 -> sum=9'h1FF, bout=1.
REQ-029 Extremes (N=8):
- in1=255, in2=0, cin=0 -> sum=9'h0FF;
- in1=0, in2=255, cin=1 -> sum=9'h100, bout=1.
REQ-030 Register path:
- rst=1 for 2 edges with in1=200, in2=50 -> sum_q=0 while sum=150;
- release rst -> sum_q=150 after the next edge;
- change inputs to in1=10, in2=20 -> sum_q=9'h1F6 one edge later.
REQ-031 Parameter sweep: N=1 (exhaustive over 8 cases) and N=16 (random 10000 vectors plus 0/max corners) -> REQ-011 holds for every vector.
